// File: rtl/ex_stall_ctrl.sv
// EX stall controller: sequences madd two-step and divider handshake,
// merges ID/EX/MEM stall requests into the 6-bit pipeline stall vector.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : pipeline flush, cancels any multi-cycle op
//   stallreq_id   : ID load-use hazard request
//   stallreq_mem  : MEM not-ready request
//   ex_madd       : EX holds madd/maddu/msub/msubu
//   ex_div        : EX holds div/divu
//   div_ready     : divider result valid
//   stall         : [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb, 1 = stop
//   cnt_o         : madd step index to EX
//   div_start     : divider start level
//   div_cancel    : one-cycle divider abort
//   div_err       : one-cycle divider timeout pulse
//   busy          : FSM not idle
module ex_stall_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       stallreq_id,
  input  logic       stallreq_mem,
  input  logic       ex_madd,
  input  logic       ex_div,
  input  logic       div_ready,
  output logic [5:0] stall,
  output logic [1:0] cnt_o,
  output logic       div_start,
  output logic       div_cancel,
  output logic       div_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MADD2    = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cnt_nxt;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] wcnt_nxt;
  logic             done;
  logic             done_nxt;
  logic             err_nxt;
  logic             ex_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt_o   <= 2'd0;
      wcnt    <= '0;
      done    <= 1'b0;
      div_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_o   <= cnt_nxt;
      wcnt    <= wcnt_nxt;
      done    <= done_nxt;
      div_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_o;
    wcnt_nxt   = wcnt;
    done_nxt   = done;
    err_nxt    = 1'b0;
    ex_req     = 1'b0;
    stall      = STALL_NONE;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    busy       = (state != IDLE);

    if (rst) begin
      busy = 1'b0;
    end else if (flush) begin
      state_nxt  = IDLE;
      cnt_nxt    = 2'd0;
      wcnt_nxt   = '0;
      done_nxt   = 1'b0;
      div_cancel = (state == DIV_WAIT);
    end else if (stallreq_mem) begin
      // Everything frozen; a result landing now is remembered in done.
      stall = STALL_MEM;
      if (state == DIV_WAIT) begin
        div_start = 1'b1;
        if (div_ready) done_nxt = 1'b1;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (ex_madd) begin
            ex_req    = 1'b1;
            state_nxt = MADD2;
            cnt_nxt   = 2'd1;
          end else if (ex_div) begin
            ex_req    = 1'b1;
            div_start = 1'b1;
            state_nxt = DIV_WAIT;
            wcnt_nxt  = '0;
          end
        end
        MADD2: begin
          cnt_nxt   = 2'd0;
          state_nxt = IDLE;
        end
        DIV_WAIT: begin
          div_start = 1'b1;
          if (div_ready || done) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
          end else if (wcnt == WAIT_LAST) begin
            // Timeout: abort divider and release the pipe.
            div_cancel = 1'b1;
            err_nxt    = 1'b1;
            state_nxt  = IDLE;
            wcnt_nxt   = '0;
          end else begin
            ex_req   = 1'b1;
            wcnt_nxt = wcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase

      if (ex_req) stall = STALL_EX;
      else if (stallreq_id) stall = STALL_ID;
    end
  end

endmodule

// File: tb/tb_ex_stall_ctrl.sv
// Directed-vector bench for ex_stall_ctrl.
// Expected values are hand-derived from the block behaviour.
module tb_ex_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       stallreq_id;
  logic       stallreq_mem;
  logic       ex_madd;
  logic       ex_div;
  logic       div_ready;
  logic [5:0] stall;
  logic [1:0] cnt_o;
  logic       div_start;
  logic       div_cancel;
  logic       div_err;
  logic       busy;

  int checks;
  int failures;

  ex_stall_ctrl #(
    .DIV_TIMEOUT(40),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .stallreq_id(stallreq_id),
    .stallreq_mem(stallreq_mem),
    .ex_madd(ex_madd),
    .ex_div(ex_div),
    .div_ready(div_ready),
    .stall(stall),
    .cnt_o(cnt_o),
    .div_start(div_start),
    .div_cancel(div_cancel),
    .div_err(div_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_mem = 1'b0;
    ex_madd      = 1'b0;
    ex_div       = 1'b1;
    div_ready    = 1'b0;

    // Reset with ex_div asserted
    tick;
    check("rst_stall", {2'b0, stall}, 8'h00);
    check("rst_start", {7'b0, div_start}, 8'h00);
    check("rst_cnt", {6'b0, cnt_o}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    tick;
    ex_div = 1'b0;
    rst    = 1'b0;
    #1;
    check("idle_stall", {2'b0, stall}, 8'h00);

    // madd two-step
    ex_madd = 1'b1;
    #1;
    check("madd_c0_stall", {2'b0, stall}, 8'h0f);
    check("madd_c0_cnt", {6'b0, cnt_o}, 8'h00);
    tick;
    check("madd_c1_stall", {2'b0, stall}, 8'h00);
    check("madd_c1_cnt", {6'b0, cnt_o}, 8'h01);
    check("madd_c1_busy", {7'b0, busy}, 8'h01);
    tick;
    ex_madd = 1'b0;
    #1;
    check("madd_c2_cnt", {6'b0, cnt_o}, 8'h00);
    check("madd_c2_busy", {7'b0, busy}, 8'h00);

    // div with ready after 33 stalled cycles
    ex_div = 1'b1;
    #1;
    check("div_c0_stall", {2'b0, stall}, 8'h0f);
    check("div_c0_start", {7'b0, div_start}, 8'h01);
    tick;
    for (int i = 1; i <= 32; i++) begin
      check("div_wait_stall", {2'b0, stall}, 8'h0f);
      check("div_wait_start", {7'b0, div_start}, 8'h01);
      tick;
    end
    div_ready = 1'b1;
    #1;
    check("div_rdy_stall", {2'b0, stall}, 8'h00);
    check("div_rdy_start", {7'b0, div_start}, 8'h01);
    tick;
    ex_div    = 1'b0;
    div_ready = 1'b0;
    #1;
    check("div_done_busy", {7'b0, busy}, 8'h00);
    check("div_done_start", {7'b0, div_start}, 8'h00);

    // div timeout
    ex_div = 1'b1;
    #1;
    check("to_c0_stall", {2'b0, stall}, 8'h0f);
    tick;
    for (int i = 1; i <= 39; i++) begin
      check("to_wait_stall", {2'b0, stall}, 8'h0f);
      check("to_wait_cancel", {7'b0, div_cancel}, 8'h00);
      tick;
    end
    check("to_cancel", {7'b0, div_cancel}, 8'h01);
    check("to_stall", {2'b0, stall}, 8'h00);
    check("to_err_early", {7'b0, div_err}, 8'h00);
    tick;
    ex_div = 1'b0;
    #1;
    check("to_err", {7'b0, div_err}, 8'h01);
    check("to_busy", {7'b0, busy}, 8'h00);
    check("to_cancel_off", {7'b0, div_cancel}, 8'h00);
    tick;
    check("to_err_clr", {7'b0, div_err}, 8'h00);

    // MEM overlap in DIV_WAIT with a div_ready pulse
    ex_div = 1'b1;
    tick;
    tick;
    tick;
    stallreq_mem = 1'b1;
    div_ready    = 1'b1;
    #1;
    check("mem_stall0", {2'b0, stall}, 8'h1f);
    check("mem_start0", {7'b0, div_start}, 8'h01);
    tick;
    div_ready = 1'b0;
    #1;
    check("mem_stall1", {2'b0, stall}, 8'h1f);
    check("mem_busy1", {7'b0, busy}, 8'h01);
    tick;
    check("mem_stall2", {2'b0, stall}, 8'h1f);
    stallreq_mem = 1'b0;
    #1;
    check("mem_rel_stall", {2'b0, stall}, 8'h00);
    check("mem_rel_start", {7'b0, div_start}, 8'h01);
    tick;
    ex_div = 1'b0;
    #1;
    check("mem_rel_busy", {7'b0, busy}, 8'h00);

    // flush at cycle 5 of DIV_WAIT
    ex_div = 1'b1;
    tick;
    tick;
    tick;
    tick;
    tick;
    check("fl_pre_stall", {2'b0, stall}, 8'h0f);
    flush = 1'b1;
    #1;
    check("fl_cancel", {7'b0, div_cancel}, 8'h01);
    check("fl_start", {7'b0, div_start}, 8'h00);
    check("fl_stall", {2'b0, stall}, 8'h00);
    tick;
    flush  = 1'b0;
    ex_div = 1'b0;
    #1;
    check("fl_busy", {7'b0, busy}, 8'h00);
    check("fl_err", {7'b0, div_err}, 8'h00);
    check("fl_cancel_off", {7'b0, div_cancel}, 8'h00);
    tick;
    check("fl_err2", {7'b0, div_err}, 8'h00);

    // ID request alone and combined with madd
    stallreq_id = 1'b1;
    #1;
    check("id_only", {2'b0, stall}, 8'h07);
    ex_madd = 1'b1;
    #1;
    check("id_madd", {2'b0, stall}, 8'h0f);
    tick;
    ex_madd = 1'b0;
    #1;
    check("id_madd2", {2'b0, stall}, 8'h07);
    check("id_madd2_cnt", {6'b0, cnt_o}, 8'h01);
    tick;
    stallreq_id = 1'b0;
    #1;
    check("id_end_cnt", {6'b0, cnt_o}, 8'h00);
    check("id_end_busy", {7'b0, busy}, 8'h00);

    // madd and div together: madd path wins
    ex_madd = 1'b1;
    ex_div  = 1'b1;
    #1;
    check("both_start", {7'b0, div_start}, 8'h00);
    check("both_stall", {2'b0, stall}, 8'h0f);
    tick;
    ex_madd = 1'b0;
    ex_div  = 1'b0;
    #1;
    check("both_busy", {7'b0, busy}, 8'h01);
    check("both_cnt", {6'b0, cnt_o}, 8'h01);
    tick;

    // MEM request freezes IDLE while madd is pending
    stallreq_mem = 1'b1;
    ex_madd      = 1'b1;
    #1;
    check("memi_stall", {2'b0, stall}, 8'h1f);
    tick;
    check("memi_busy", {7'b0, busy}, 8'h00);
    check("memi_cnt", {6'b0, cnt_o}, 8'h00);
    stallreq_mem = 1'b0;
    #1;
    check("memi_rel", {2'b0, stall}, 8'h0f);
    tick;
    ex_madd = 1'b0;
    #1;
    check("memi_cnt1", {6'b0, cnt_o}, 8'h01);
    tick;
    check("memi_end", {7'b0, busy}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stall_ctrl.md
Name: ex_stall_ctrl

Overview:
Pipeline stall controller for the 5-stage MIPS core; sequences multi-cycle EX operations (madd/msub two-step accumulate, div/divu handshake) and merges stall requests from ID and MEM into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Drives the EX step counter cnt and the divider start/cancel handshake. Sits beside the pipeline registers, fed by id, ex, mem and the divider.

Parameters:
DIV_TIMEOUT, 40, max cycles in DIV_WAIT before abort (must be < 2^CNT_W)
CNT_W, 6, width of divider wait counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  pipeline flush (exception/eret); cancels any multi-cycle op
stallreq_id  input  1  ID load-use hazard request
stallreq_mem  input  1  MEM wait request (memory not ready)
ex_madd  input  1  EX holds madd/maddu/msub/msubu
ex_div  input  1  EX holds div/divu
div_ready  input  1  divider result valid (held by divider until start drops)
stall  output  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = STOP
cnt_o  output  2  madd step index to EX (0 = first step, 1 = second step)
div_start  output  1  divider start, level, held until result accepted
div_cancel  output  1  one-cycle divider abort
div_err  output  1  one-cycle pulse on divider timeout
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=1 at edge): state=IDLE, cnt_o=0, wait counter=0, done flag=0, div_err=0; combinational outputs then evaluate to stall=6'b000000, div_start=0, div_cancel=0, busy=0.
- States: IDLE, MADD2, DIV_WAIT. cnt_o, div_err registered; stall, div_start, div_cancel, busy combinational from state and inputs.
- Stall encodings: MEM request 6'b011111; EX request 6'b001111; ID request 6'b000111; none 6'b000000.
- Priority per cycle: rst > flush > stallreq_mem > EX FSM request > stallreq_id.
- IDLE, ex_madd=1: EX request this cycle; next state MADD2, cnt_o<=1. EX stores first partial result into its hilo temp (held by ex_mem while stall[3]=1, stall[4]=0).
- MADD2: no EX request (stall from other sources only); cnt_o<=0; next IDLE. Total madd occupancy 2 cycles.
- IDLE, ex_div=1 (ex_madd=0): div_start=1, EX request; next DIV_WAIT, counter<=0.
- DIV_WAIT: div_start=1. If div_ready=1 or done flag=1: no EX request, div_start still 1 this cycle, next IDLE, done<=0. Else EX request, counter+1; if counter reaches DIV_TIMEOUT-1: div_cancel=1, div_err<=1 (pulse next cycle), next IDLE, stall released.
- ex_madd and ex_div both 1 in IDLE: madd path taken (decoder never issues both; bench checks determinism only).
- stallreq_mem=1: stall=6'b011111; state, cnt_o and counter frozen; in DIV_WAIT a div_ready arriving sets done<=1 so the result is consumed once MEM releases.
- flush=1: stall=0; next state IDLE, cnt_o<=0, counter<=0, done<=0; div_cancel=1 if state was DIV_WAIT; div_start=0 that cycle; no div_err.
- stallreq_id while FSM requests EX stall: EX encoding wins (superset).
- div_err high exactly one cycle; cleared by next edge or rst.
- Counter never wraps: timeout exits before reaching 2^CNT_W.

Test Plan:
- Reset: rst=1 two cycles with ex_div=1 -> stall=0, div_start=0, cnt_o=0, busy=0 after first edge.
- madd: ex_madd=1 in IDLE -> cycle0 stall=6'b001111 cnt_o=0; cycle1 stall=0 cnt_o=1; cycle2 cnt_o=0, IDLE.
- div: ex_div=1, div_ready after 33 cycles -> stall=6'b001111 and div_start=1 for 33 cycles, release on div_ready cycle, busy=0 next.
- Timeout: ex_div=1, div_ready never -> after 40 cycles div_cancel=1 one cycle, div_err pulse next cycle, stall=0.
- MEM overlap: DIV_WAIT, stallreq_mem=1 with div_ready pulse -> stall=6'b011111 held; after mem release stall=0 in first cycle, IDLE next.
- Flush: flush=1 at cycle 5 of DIV_WAIT -> div_cancel=1, div_start=0, stall=0, next IDLE, no div_err; stallreq_id alone -> stall=6'b000111.
